mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Shares the single unified memory bus between the IF stage (instruction fetch) and the MEM stage (loads/stores) of the five-stage pipeline. It grants one requester at a time and holds the bus for a fixed access latency. It returns read data with a one-cycle completion pulse and drives per-stage stall signals so the pipeline freezes while its access is outstanding. Bus command encoding is `BUS_NONE` / `BUS_LOAD` / `BUS_STORE` from `sys_defs.vh`.

## Interface
- MEM_LATENCY, 2, cycles the bus is held per access (legal range ≥1)
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  IF stage requests an instruction read
- if_addr  in  32  fetch address
- if_rdata  out  32  fetched instruction
- if_rvld  out  1  one-cycle pulse: if_rdata valid, IF access complete
- if_stall  out  1  IF must hold (request pending, not complete)
- mem_cmd  in  2  MEM stage command (BUS_NONE/BUS_LOAD/BUS_STORE)
- mem_addr  in  32  data address
- mem_wdata  in  32  store data
- mem_rdata  out  32  load data
- mem_done  out  1  one-cycle pulse: MEM access complete
- mem_stall  out  1  MEM must hold (command pending, not complete)
- bus_cmd  out  2  command to memory
- bus_addr  out  32  address to memory
- bus_wdata  out  32  write data to memory
- bus_rdata  in  32  read data from memory, valid in the last held cycle

## Operation
- States: IDLE, IF_ACC, MEM_ACC. Registers: state, down-counter cnt (width $clog2(MEM_LATENCY+1)), latched cmd/addr/wdata, last_gnt (IF/MEM), if_rdata, mem_rdata, if_rvld, mem_done.
- Effective requests in IDLE: if_p = if_req & ~if_rvld; mem_p = (mem_cmd != BUS_NONE) & ~mem_done. This masking prevents re-granting a requester in its completion cycle.
- IDLE arbitration:
  - Only mem_p → MEM_ACC.
  - Only if_p → IF_ACC.
  - Both → the one that is not last_gnt.
  - Neither → stay IDLE.
- On grant: latch addr (and cmd/wdata for MEM; cmd = BUS_LOAD for IF), set cnt = MEM_LATENCY, update last_gnt.
- In IF_ACC/MEM_ACC: bus_* driven from the latched registers; cnt decrements each cycle.
- When cnt == 1: sample bus_rdata into if_rdata (IF) or mem_rdata (MEM, loads only; stores leave mem_rdata unchanged). Pulse if_rvld/mem_done next cycle. Go to IDLE.
- In IDLE: bus_cmd = BUS_NONE. bus_addr/bus_wdata hold last latched values.
- Stalls are combinational:
  - if_stall = if_req & ~if_rvld
  - mem_stall = (mem_cmd != BUS_NONE) & ~mem_done
- Requester inputs changing during an access are ignored. Only latched values drive the bus.

## Timing
- Request seen in IDLE at cycle t → bus driven cycles t+1 … t+MEM_LATENCY → rvld/done high in cycle t+MEM_LATENCY+1 only.
- Back-to-back: new grant decision in the completion cycle, t+MEM_LATENCY+1. Bus idle (BUS_NONE) for exactly that one cycle between accesses.
- Fairness: with both requesters continuously pending, grants strictly alternate. Neither waits more than one foreign access.
- Reset values: state IDLE, cnt 0, bus_cmd BUS_NONE, bus_addr 0, bus_wdata 0, if_rdata 0, mem_rdata 0, if_rvld 0, mem_done 0, last_gnt IF (first tie goes to MEM).
- Reset mid-access aborts the access: no rvld/done pulse, and bus_cmd is BUS_NONE the cycle after reset.
- MEM_LATENCY=1: bus held exactly one cycle, completion in t+2.

## Test plan
- Reset, then IF only: if_req=1, if_addr=0x100, MEM_LATENCY=2, bus_rdata=0x00500093 → bus_cmd=LOAD, addr 0x100 in cycles 1–2. if_rvld=1 and if_rdata=0x00500093 in cycle 3. if_stall=1 in cycles 0–2, 0 in cycle 3.
- Simultaneous first requests: if_req, mem_cmd=BUS_LOAD at 0x2000 at cycle 0 → MEM granted first. mem_done at cycle 3. IF granted cycle 3, bus_addr=if_addr cycles 4–5, if_rvld cycle 6.
- Store: mem_cmd=BUS_STORE, addr 0x40, wdata 0xDEADBEEF → bus_cmd=STORE, wdata 0xDEADBEEF for 2 cycles. mem_done pulse. mem_rdata unchanged.
- Continuous contention for 8 accesses → grants alternate MEM, IF, MEM, …; no requester is granted twice in a row.
- Reset asserted in the second held cycle of an IF access → next cycle: bus_cmd=BUS_NONE, if_rvld=0, state IDLE. A request after reset is served with full latency.
- Completion-cycle masking: IF holds if_req high through its if_rvld cycle with the same address → exactly one access occurs per request, with no duplicate grant.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Purpose: shares one memory bus between instruction fetch and load/store, one access at a time.
// Latency: bus held MEM_LATENCY cycles after grant; completion pulse in the following cycle.
// Backpressure: a waiting or in-flight requester sees its stall high until its completion pulse.
module mem_bus_arbiter #(
  parameter int MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_rvld,
  output logic        if_stall,
  input  logic [1:0]  mem_cmd,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_done,
  output logic        mem_stall,
  output logic [1:0]  bus_cmd,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata
);

  // Bus command encoding shared with the rest of the pipeline.
  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;

  localparam int CW = $clog2(MEM_LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_ACC  = 2'd1,
    MEM_ACC = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_cmd;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_if_rdata;
  logic [31:0]   r_mem_rdata;
  logic          r_if_rvld;
  logic          r_mem_done;
  logic          r_last_gnt_mem;  // 0: IF was granted last, 1: MEM was granted last

  logic          w_if_p;
  logic          w_mem_p;
  logic          w_gnt_if;
  logic          w_gnt_mem;
  logic          w_last;

  // A requester is masked in its own completion cycle so the same request
  // is not granted a second time while the pipeline is still advancing.
  assign w_if_p  = if_req & ~r_if_rvld;
  assign w_mem_p = (mem_cmd != BUS_NONE) & ~r_mem_done;
  assign w_last  = (r_cnt == CW'(1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and grant decision; on a tie the requester not served last wins.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_if    = 1'b0;
    w_gnt_mem   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_mem_p && (!w_if_p || !r_last_gnt_mem)) begin
          w_gnt_mem   = 1'b1;
          w_state_nxt = MEM_ACC;
        end else if (w_if_p) begin
          w_gnt_if    = 1'b1;
          w_state_nxt = IF_ACC;
        end
      end
      IF_ACC, MEM_ACC: begin
        if (w_last) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Latch the granted request, count down the access and capture read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt          <= '0;
      r_cmd          <= BUS_NONE;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_if_rdata     <= '0;
      r_mem_rdata    <= '0;
      r_if_rvld      <= 1'b0;
      r_mem_done     <= 1'b0;
      r_last_gnt_mem <= 1'b0;
    end else begin
      r_if_rvld  <= 1'b0;
      r_mem_done <= 1'b0;
      if (w_gnt_mem) begin
        r_cmd          <= mem_cmd;
        r_addr         <= mem_addr;
        r_wdata        <= mem_wdata;
        r_cnt          <= CW'(MEM_LATENCY);
        r_last_gnt_mem <= 1'b1;
      end else if (w_gnt_if) begin
        r_cmd          <= BUS_LOAD;
        r_addr         <= if_addr;
        r_cnt          <= CW'(MEM_LATENCY);
        r_last_gnt_mem <= 1'b0;
      end else if (r_state != IDLE) begin
        r_cnt <= r_cnt - CW'(1);
        if (w_last) begin
          if (r_state == IF_ACC) begin
            r_if_rdata <= bus_rdata;
            r_if_rvld  <= 1'b1;
          end else begin
            // Stores complete without touching the load data register.
            if (r_cmd == BUS_LOAD) begin
              r_mem_rdata <= bus_rdata;
            end
            r_mem_done <= 1'b1;
          end
        end
      end
    end
  end

  assign bus_cmd   = (r_state == IDLE) ? BUS_NONE : r_cmd;
  assign bus_addr  = r_addr;
  assign bus_wdata = r_wdata;

  assign if_rdata  = r_if_rdata;
  assign if_rvld   = r_if_rvld;
  assign mem_rdata = r_mem_rdata;
  assign mem_done  = r_mem_done;

  assign if_stall  = if_req & ~r_if_rvld;
  assign mem_stall = (mem_cmd != BUS_NONE) & ~r_mem_done;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Purpose: scoreboard bench for mem_bus_arbiter with directed, hand-computed vectors.
// Latency: expected bus cycles and completion cycles are pushed when stimulus is issued.
// Backpressure: monitors pop and compare whenever the DUT drives the bus or pulses completion.
module tb_mem_bus_arbiter;

  localparam int         LAT   = 2;
  localparam logic [1:0] NONE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] STORE = 2'd2;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_rvld;
  logic        if_stall;
  logic [1:0]  mem_cmd;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic        mem_stall;
  logic [1:0]  bus_cmd;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;

  logic        use_fixed;
  logic [31:0] fixed_rdata;

  mem_bus_arbiter #(.MEM_LATENCY(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_rvld   (if_rvld),
    .if_stall  (if_stall),
    .mem_cmd   (mem_cmd),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_done  (mem_done),
    .mem_stall (mem_stall),
    .bus_cmd   (bus_cmd),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: either a fixed word or C0DE in the upper half, low address bits below.
  always_comb bus_rdata = use_fixed ? fixed_rdata : {16'hC0DE, bus_addr[15:0]};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  cmd;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          chk_w;
    int          cyc;
  } bus_exp_t;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } cmp_exp_t;

  bus_exp_t bus_q[$];
  cmp_exp_t if_q[$];
  cmp_exp_t mem_q[$];
  bus_exp_t be;
  cmp_exp_t ie;
  cmp_exp_t me;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expect one bus access granted in cycle t0: bus driven t0+1 .. t0+LAT.
  task automatic exp_bus(input logic [1:0] c, input logic [31:0] a, input logic [31:0] w,
                         input bit cw, input int t0);
    for (int k = 1; k <= LAT; k++) bus_q.push_back('{c, a, w, cw, t0 + k});
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    if_req    = 1'b0;
    mem_cmd   = NONE;
    tick();
    tick();
    @(negedge clk);
    chk("rst_bus_cmd",   64'(bus_cmd),   64'(NONE));
    chk("rst_bus_addr",  64'(bus_addr),  64'h0);
    chk("rst_bus_wdata", 64'(bus_wdata), 64'h0);
    chk("rst_if_rdata",  64'(if_rdata),  64'h0);
    chk("rst_mem_rdata", 64'(mem_rdata), 64'h0);
    chk("rst_if_rvld",   64'(if_rvld),   64'h0);
    chk("rst_mem_done",  64'(mem_done),  64'h0);
    chk("rst_if_stall",  64'(if_stall),  64'h0);
    chk("rst_mem_stall", 64'(mem_stall), 64'h0);
    tick();
    rst = 1'b0;
  endtask

  // Bus monitor: every non-idle bus cycle must match the next expected one.
  always @(negedge clk) begin
    if (bus_cmd != NONE) begin
      if (bus_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL bus_unexpected: got cmd %0d addr %h expected idle bus (cycle %0d)",
                 bus_cmd, bus_addr, cyc);
      end else begin
        be = bus_q.pop_front();
        chk("bus_cmd",   64'(bus_cmd),  64'(be.cmd));
        chk("bus_addr",  64'(bus_addr), 64'(be.addr));
        if (be.chk_w) chk("bus_wdata", 64'(bus_wdata), 64'(be.wdata));
        chk("bus_cycle", 64'(cyc),      64'(be.cyc));
      end
    end
  end

  // IF completion monitor.
  always @(negedge clk) begin
    if (if_rvld === 1'b1) begin
      if (if_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL if_rvld_unexpected: got pulse expected none (cycle %0d)", cyc);
      end else begin
        ie = if_q.pop_front();
        chk("if_rdata",     64'(if_rdata), 64'(ie.data));
        chk("if_rvld_cyc",  64'(cyc),      64'(ie.cyc));
      end
    end
  end

  // MEM completion monitor.
  always @(negedge clk) begin
    if (mem_done === 1'b1) begin
      if (mem_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mem_done_unexpected: got pulse expected none (cycle %0d)", cyc);
      end else begin
        me = mem_q.pop_front();
        chk("mem_rdata",    64'(mem_rdata), 64'(me.data));
        chk("mem_done_cyc", 64'(cyc),       64'(me.cyc));
      end
    end
  end

  initial begin
    int t;
    rst         = 1'b1;
    if_req      = 1'b0;
    if_addr     = '0;
    mem_cmd     = NONE;
    mem_addr    = '0;
    mem_wdata   = '0;
    use_fixed   = 1'b0;
    fixed_rdata = '0;

    // IF only; if_req held through its completion cycle (no duplicate grant).
    do_reset();
    tick();
    t           = cyc;
    use_fixed   = 1'b1;
    fixed_rdata = 32'h0050_0093;
    if_req      = 1'b1;
    if_addr     = 32'h0000_0100;
    exp_bus(LOAD, 32'h100, 32'h0, 1'b0, t);
    if_q.push_back('{32'h0050_0093, t + 3});
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t1_if_stall", 64'(if_stall), (k < 3) ? 64'h1 : 64'h0);
      tick();
    end
    if_req = 1'b0;
    repeat (3) tick();

    // Simultaneous first requests after reset: MEM wins the first tie.
    do_reset();
    tick();
    t         = cyc;
    use_fixed = 1'b0;
    if_req    = 1'b1;
    if_addr   = 32'h0000_0300;
    mem_cmd   = LOAD;
    mem_addr  = 32'h0000_2000;
    exp_bus(LOAD, 32'h2000, 32'h0, 1'b0, t);
    mem_q.push_back('{32'hC0DE_2000, t + 3});
    exp_bus(LOAD, 32'h300, 32'h0, 1'b0, t + 3);
    if_q.push_back('{32'hC0DE_0300, t + 6});
    @(negedge clk);
    chk("t2_mem_stall_req", 64'(mem_stall), 64'h1);
    chk("t2_if_stall_req",  64'(if_stall),  64'h1);
    repeat (3) tick();
    @(negedge clk);
    chk("t2_mem_stall_done", 64'(mem_stall), 64'h0);
    tick();
    mem_cmd = NONE;
    @(negedge clk);
    chk("t2_if_stall_wait", 64'(if_stall), 64'h1);
    repeat (2) tick();
    @(negedge clk);
    chk("t2_if_stall_done", 64'(if_stall), 64'h0);
    tick();
    if_req = 1'b0;
    repeat (2) tick();

    // Store: inputs changed mid-access must be ignored; mem_rdata keeps the last load.
    tick();
    t         = cyc;
    mem_cmd   = STORE;
    mem_addr  = 32'h0000_0040;
    mem_wdata = 32'hDEAD_BEEF;
    exp_bus(STORE, 32'h40, 32'hDEAD_BEEF, 1'b1, t);
    mem_q.push_back('{32'hC0DE_2000, t + 3});
    tick();
    mem_addr  = 32'h0000_0999;
    mem_wdata = 32'h0;
    repeat (3) tick();
    mem_cmd = NONE;
    repeat (2) tick();

    // Continuous contention, 8 accesses: MEM, IF, MEM, ... one idle cycle between each.
    do_reset();
    tick();
    t        = cyc;
    if_req   = 1'b1;
    if_addr  = 32'h0000_0500;
    mem_cmd  = LOAD;
    mem_addr = 32'h0000_0600;
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) begin
        exp_bus(LOAD, 32'h600, 32'h0, 1'b0, t + 3 * k);
        mem_q.push_back('{32'hC0DE_0600, t + 3 * k + 3});
      end else begin
        exp_bus(LOAD, 32'h500, 32'h0, 1'b0, t + 3 * k);
        if_q.push_back('{32'hC0DE_0500, t + 3 * k + 3});
      end
    end
    repeat (24) tick();
    if_req  = 1'b0;
    mem_cmd = NONE;
    repeat (3) tick();

    // Reset in the second held cycle of an IF access aborts it; retry gets full latency.
    tick();
    t       = cyc;
    if_req  = 1'b1;
    if_addr = 32'h0000_0700;
    exp_bus(LOAD, 32'h700, 32'h0, 1'b0, t);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_bus(LOAD, 32'h700, 32'h0, 1'b0, t + 3);
    if_q.push_back('{32'hC0DE_0700, t + 6});
    @(negedge clk);
    chk("t5_bus_cmd_after_rst", 64'(bus_cmd),  64'(NONE));
    chk("t5_if_rvld_after_rst", 64'(if_rvld),  64'h0);
    chk("t5_if_rdata_cleared",  64'(if_rdata), 64'h0);
    chk("t5_if_stall_pending",  64'(if_stall), 64'h1);
    repeat (4) tick();
    if_req = 1'b0;
    repeat (4) tick();

    chk("bus_q_remaining", 64'(bus_q.size()), 64'h0);
    chk("if_q_remaining",  64'(if_q.size()),  64'h0);
    chk("mem_q_remaining", 64'(mem_q.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
